spi16: RTL and testbench
========================

# spi16

Write-only, 16-bit, MSB-first serializer for the OFDM transmitter output path. It takes one parallel word per frame from the upstream datapath (`valid` + `data_in`). It drives it on `mosi`, one bit per `sclk` cycle, framed by the active-low chip select `cs_n`. Frames repeat every 18 clocks while `valid` stays high, so upstream can update `data_in` on a fixed 18-cycle cadence.

## Interface
- `WIDTH`, default 16: word length in bits, which is also the number of shift cycles per frame.
- `sclk`, input, 1 bit: the single system clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `data_in`, input, `WIDTH` bits: parallel word. It is sampled only on the capture edge.
- `valid`, input, 1 bit: level request to send. It is sampled only in IDLE.
- `mosi`, output, 1 bit: serial data, MSB first. Registered.
- `cs_n`, output, 1 bit: frame enable, active low. Registered.

## Operation
- States: IDLE, SHIFT, GAP. A 4-bit bit counter and a `WIDTH`-bit shift register hold the frame.
- **IDLE:** `cs_n`=1, `mosi`=0.
  - If `valid`=1 on the rising edge, this is the capture edge. Load the shift register with `data_in`, set the counter to `WIDTH`-1, and go to SHIFT.
  - On that same edge, drive `cs_n`=0 and `mosi`=`data_in`[`WIDTH`-1].
- **SHIFT:** `cs_n`=0, and `mosi` shows the current bit.
  - Each edge shifts left by one and decrements the counter, so `mosi` presents bit `WIDTH`-2 down to bit 0.
  - On the edge where the counter is 0, the last bit has been shown for one cycle. Go to GAP with `cs_n`=1 and `mosi`=0.
- **GAP:** `cs_n`=1, `mosi`=0. Return to IDLE unconditionally after one cycle.
- `valid` and `data_in` are ignored outside IDLE. There is no back-pressure output; upstream must respect the 18-cycle cadence.
- If `valid` is low in IDLE, stay in IDLE indefinitely with the outputs at their idle values.
- If `valid` deasserts mid-frame, the current frame still completes.
- **Reset** (`reset`=0, at any time including mid-frame):
  - Force IDLE immediately and asynchronously: `cs_n`=1, `mosi`=0, shift register and counter cleared.
  - The partial frame is abandoned.
  - After release, the first capture can occur on the first rising edge with `valid`=1.

## Timing
- Latency: `cs_n` falls and the MSB appears on `mosi` at the capture edge itself (registered output, valid after clock-to-out).
- `cs_n` is low for exactly `WIDTH` (16) cycles; each bit is held for exactly one cycle.
- `cs_n` is high for a minimum of 2 cycles between frames (GAP + IDLE).
- With `valid` held high, the frame period is exactly `WIDTH`+2 = 18 cycles, and captures occur every 18 edges.
- `mosi` and `cs_n` change only on rising edges of `sclk` (or on reset assertion). The receiver samples on the next rising edge (or the falling edge) of `sclk`.
- No serial clock is output; the receiver shares `sclk`.

## Structure
- A shared package holds:
  - a state enum (IDLE/SHIFT/GAP);
  - the constant `SPI_WORD_W`=16;
  - the gap length constant `SPI_GAP_CYC`=1.
- A single flat module is sufficient. An optional sub-module `spi16_shreg` (a loadable left-shift register with MSB tap) is natural if the shift path is reused elsewhere.

## Test plan
- **Reset hold:** `reset`=0 for 5 cycles with `valid`=1 -> `cs_n`=1 and `mosi`=0 throughout, with no frame started.
- **Single frame:** release reset, then `valid`=1 with `data_in`=16'hA5A5.
  - Over 16 cycles after the capture edge, with `cs_n`=0, `mosi` = 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1.
  - Then `cs_n`=1 for at least 2 cycles.
- **Back-to-back frames:** `valid` held 1, with `data_in` changing every 18 cycles just before each capture edge: A5A5, 73AC, 0123, 4567, 89AB.
  - Five frames with period 18 cycles and 2 high cycles of `cs_n` between them.
  - Second frame `mosi` = 0111001110101100.
- **Mid-frame input change:** change `data_in` to 16'hFFFF 5 cycles into an A5A5 frame -> the serialized frame is still A5A5, and FFFF goes out only if still present at the next capture edge.
- **Reset mid-frame:** assert `reset`=0 at bit 7 of a frame -> `cs_n`=1 and `mosi`=0 asynchronously. After release with `valid`=1, a fresh full 16-bit frame starts.
- **Valid deassert:** drop `valid` after the capture edge -> the current frame completes (16 bits), then `cs_n` stays 1 indefinitely.

Source files
------------

// File: rtl/spi16_pkg.sv
// -----------------------------------------------------------------------------
// spi16_pkg
// Shared definitions for the spi16 write-only serializer.
//   spi_state_e  : frame FSM states (IDLE / SHIFT / GAP)
//   SPI_WORD_W   : default word length, also the number of shift cycles
//   SPI_GAP_CYC  : number of GAP cycles after the last data bit
//   spi_cnt_w    : width of the bit counter for a given word length
// -----------------------------------------------------------------------------
package spi16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } spi_state_e;

  localparam int SPI_WORD_W  = 16;
  localparam int SPI_GAP_CYC = 1;

  // Counter must hold WIDTH-1; a 16-bit word gives a 4-bit counter.
  function automatic int spi_cnt_w(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi16_shreg.sv
// -----------------------------------------------------------------------------
// spi16_shreg
// Loadable left-shift register with an MSB tap. Zeros are shifted in at the
// LSB, so after WIDTH shifts the register (and the MSB tap) reads zero.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, clears the register
//   i_load   : load i_d (has priority over i_shift)
//   i_shift  : shift left by one, zero into the LSB
//   i_d      : parallel load word
//   o_msb    : current MSB of the register
// -----------------------------------------------------------------------------
module spi16_shreg
  import spi16_pkg::*;
#(
  parameter int WIDTH = SPI_WORD_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  // shift register: async clear, load has priority over shift
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/spi16.sv
// -----------------------------------------------------------------------------
// spi16
// Write-only MSB-first serializer. A word is captured from data_in on the
// first rising edge in IDLE with valid high; cs_n drops and the MSB appears on
// mosi at that same edge. Each following edge presents the next bit, cs_n
// stays low for exactly WIDTH cycles, then GAP and IDLE keep cs_n high for
// two cycles, giving a WIDTH+2 cycle frame period while valid stays high.
// Ports:
//   sclk     : system clock, all state changes on the rising edge
//   reset    : asynchronous active-low reset, abandons any frame in flight
//   data_in  : parallel word, sampled only on the capture edge
//   valid    : level request to send, sampled only in IDLE
//   mosi     : serial data, MSB first (flop output)
//   cs_n     : active-low frame enable (flop output)
// -----------------------------------------------------------------------------
module spi16
  import spi16_pkg::*;
#(
  parameter int WIDTH = SPI_WORD_W
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             mosi,
  output logic             cs_n
);

  localparam int CNT_W = spi_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(SPI_GAP_CYC - 1);

  spi_state_e       r_state;
  spi_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_cs_n;
  logic             w_cs_n_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;

  // state register, bit/gap counter and registered chip select
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs_n  <= w_cs_n_nxt;
    end
  end

  // next-state, counter and shift-path control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cs_n_nxt  = 1'b1;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid) begin
          // capture edge: MSB and cs_n low appear right at this edge
          w_load      = 1'b1;
          w_cnt_nxt   = CNT_LAST;
          w_cs_n_nxt  = 1'b0;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // shifting also on the final edge empties the register, so mosi
        // returns to 0 together with cs_n going high
        w_shift = 1'b1;
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_GAP;
          w_cs_n_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
          w_cs_n_nxt  = 1'b0;
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  spi16_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .i_clk   (sclk),
    .i_rst_n (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (data_in),
    .o_msb   (w_msb)
  );

  // mosi is the register MSB, which is itself a flop and reads zero
  // whenever no frame is in flight
  assign mosi = w_msb;
  assign cs_n = r_cs_n;

endmodule

// File: tb/tb_spi16.sv
// -----------------------------------------------------------------------------
// tb_spi16
// Self-checking bench for spi16. A queue-based reference model predicts the
// {cs_n, mosi} pair after every rising edge; table-driven frames, hand-written
// corner sequences and a randomized run are compared against it and against
// literal expected bit patterns.
// -----------------------------------------------------------------------------
module tb_spi16;
  import spi16_pkg::*;

  localparam int W = SPI_WORD_W;

  logic         sclk    = 1'b0;
  logic         reset   = 1'b0;
  logic         valid   = 1'b1;
  logic [W-1:0] data_in = 16'hA5A5;
  logic         mosi;
  logic         cs_n;

  int checks   = 0;
  int failures = 0;

  spi16 #(.WIDTH(W)) dut (
    .sclk    (sclk),
    .reset   (reset),
    .data_in (data_in),
    .valid   (valid),
    .mosi    (mosi),
    .cs_n    (cs_n)
  );

  always #5 sclk = ~sclk;

  // reference model: a frame is W low-cs_n bits MSB first, then cs_n high
  // for GAP+IDLE; a new word is accepted only once the previous frame and
  // its trailing high cycles have been fully emitted
  logic [1:0] mq[$];
  logic [1:0] m_exp = 2'b10;

  always @(posedge sclk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_exp <= 2'b10;
    end else begin
      if (mq.size() == 0 && valid) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back({1'b0, data_in[i]});
        for (int g = 0; g <= SPI_GAP_CYC; g++) mq.push_back(2'b10);
      end
      if (mq.size() != 0) m_exp <= mq.pop_front();
      else m_exp <= 2'b10;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance to the next falling edge and compare against the model
  task automatic cycle();
    @(negedge sclk);
    chk("model_cs_n", {31'd0, cs_n}, {31'd0, m_exp[1]});
    chk("model_mosi", {31'd0, mosi}, {31'd0, m_exp[0]});
  endtask

  // wait (bounded) for the capture cycle; highc counts high samples incl. current
  task automatic wait_capture(input string name, output int highc);
    highc = 1;
    cycle();
    while (cs_n !== 1'b0 && highc < 60) begin
      highc++;
      cycle();
    end
    chk({name, "_capture"}, {31'd0, cs_n}, 32'd0);
  endtask

  // receive one frame; at low-cycle chg_at apply new data_in/valid
  task automatic frame(input string name, input logic [W-1:0] exp_bits,
                       input int exp_gap, input int chg_at,
                       input logic [W-1:0] chg_d, input logic chg_v);
    int highc;
    int lowc;
    logic [W-1:0] bits;
    lowc = 0;
    bits = {W{1'b0}};
    wait_capture(name, highc);
    if (exp_gap > 0) chk({name, "_gap"}, highc, exp_gap);
    while (cs_n === 1'b0 && lowc < 20) begin
      bits = {bits[W-2:0], mosi};
      lowc++;
      if (lowc == chg_at) begin
        data_in = chg_d;
        valid   = chg_v;
      end
      cycle();
    end
    chk({name, "_bits"}, {16'd0, bits}, {16'd0, exp_bits});
    chk({name, "_low_len"}, lowc, W);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_bits;
    int           exp_gap;
  } vec_t;

  vec_t tbl[5];
  int   hc;

  initial begin
    tbl[0] = '{16'hA5A5, 16'b1010_0101_1010_0101, 0};
    tbl[1] = '{16'h73AC, 16'b0111_0011_1010_1100, 2};
    tbl[2] = '{16'h0123, 16'b0000_0001_0010_0011, 2};
    tbl[3] = '{16'h4567, 16'b0100_0101_0110_0111, 2};
    tbl[4] = '{16'h89AB, 16'b1000_1001_1010_1011, 2};

    // reset held with valid high: no frame may start
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("reset_hold_cs_n", {31'd0, cs_n}, 32'd1);
      chk("reset_hold_mosi", {31'd0, mosi}, 32'd0);
    end
    data_in = tbl[0].data;
    reset   = 1'b1;

    // single frame followed by back-to-back frames with valid held high
    for (int i = 0; i < 5; i++) begin
      frame("b2b", tbl[i].exp_bits, tbl[i].exp_gap, W,
            (i < 4) ? tbl[i + 1].data : 16'hA5A5, 1'b1);
    end

    // data_in changes 5 cycles into an A5A5 frame; FFFF goes out next,
    // and valid drops right after that capture
    frame("midchg", 16'hA5A5, 2, 5, 16'hFFFF, 1'b1);
    frame("ffff_next", 16'hFFFF, 2, 1, 16'h3C3C, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cycle();
      chk("valid_drop_idle", {31'd0, cs_n}, 32'd1);
    end

    // reset asserted around bit 7 of a frame
    data_in = 16'hA5A5;
    valid   = 1'b1;
    wait_capture("rst_mid", hc);
    repeat (8) cycle();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("async_rst_mosi", {31'd0, mosi}, 32'd0);
    cycle();
    cycle();
    data_in = 16'h0F0F;
    reset   = 1'b1;
    frame("after_rst", 16'b0000_1111_0000_1111, 0, W, 16'h0000, 1'b0);

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 800; i++) begin
      cycle();
      if (reset == 1'b0) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1;
        chk("rand_async_rst", {30'd0, cs_n, mosi}, 32'd2);
      end
      valid   = ($urandom_range(0, 9) < 7);
      data_in = 16'($urandom);
    end
    reset = 1'b1;
    valid = 1'b0;
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
